mips_lsu_avalon: RTL and testbench

Parametrised MIPS load/store unit between the core's execute stage and an Avalon-MM data master.
- Accepts one memory op per valid/ready handshake, forms the effective address and steers byte lanes.
- Stalls correctly on avm_waitrequest and returns sign/zero-extended or LWL/LWR-merged load data.
- Reports misalignment, illegal-op and bus-timeout faults instead of silently issuing bad accesses.

---
 rtl/mips_lsu_pkg.sv | 24 ++
 rtl/mips_lsu_lane_align.sv | 42 ++++
 rtl/mips_lsu_avalon.sv | 130 +++++++++++++
 tb/tb_mips_lsu_avalon.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_lsu_pkg.sv
// mips_lsu_pkg: op, fault and state encodings plus byte-enable constants for the MIPS load/store unit.
package mips_lsu_pkg;

    typedef enum logic [3:0] {
        OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR, OP_SB, OP_SH, OP_SW
    } lsu_op_t;

    typedef enum logic [1:0] {F_NONE, F_MISALIGN, F_TIMEOUT, F_ILLEGAL} fault_t;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    localparam logic [3:0] BE_ALL = 4'b1111;
    localparam logic [3:0] BE_LO  = 4'b0011;
    localparam logic [3:0] BE_HI  = 4'b1100;

    function automatic logic is_load(input logic [3:0] op);
        return op <= 4'(OP_LWR);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return op >= 4'(OP_SB) && op <= 4'(OP_SW);
    endfunction

endpackage

// File: rtl/mips_lsu_lane_align.sv
// lsu_lane_align: steers store data onto byte lanes and extracts/merges load results (little-endian).
module lsu_lane_align
    import mips_lsu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  k,
    input  logic [31:0] rt,
    input  logic [31:0] readdata,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    output logic [31:0] result
);
    logic [4:0]  sh;
    logic [31:0] shifted;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign sh      = {k, 3'b000};
    assign shifted = readdata >> sh;
    assign lane_b  = shifted[7:0];
    assign lane_h  = k[1] ? readdata[31:16] : readdata[15:0];

    assign writedata  = op == 4'(OP_SB) ? {4{rt[7:0]}} :
                        op == 4'(OP_SH) ? {2{rt[15:0]}} : rt;
    assign byteenable = op == 4'(OP_SB) ? 4'b0001 << k :
                        op == 4'(OP_SH) ? (k[1] ? BE_HI : BE_LO) : BE_ALL;

    // LWL/LWR keep the untouched register bytes from rt and shift memory into the rest
    always_comb begin
        result = readdata;
        case (lsu_op_t'(op))
            OP_LB:   result = {{24{lane_b[7]}}, lane_b};
            OP_LBU:  result = {24'd0, lane_b};
            OP_LH:   result = {{16{lane_h[15]}}, lane_h};
            OP_LHU:  result = {16'd0, lane_h};
            OP_LWL:  result = (readdata << (5'd24 - sh)) | (rt & (32'h00ff_ffff >> sh));
            OP_LWR:  result = (readdata >> sh) | (rt & ~(32'hffff_ffff >> sh));
            default: result = readdata;
        endcase
    end

endmodule

// File: rtl/mips_lsu_avalon.sv
// mips_lsu_avalon: MIPS load/store unit bridging the execute stage to an Avalon-MM data master.
module mips_lsu_avalon
    import mips_lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [31:0]       req_base,
    input  logic [15:0]       req_offset,
    input  logic [31:0]       req_store_data,
    input  logic [31:0]       req_rt_old,
    input  logic [4:0]        req_dest,
    output logic              resp_valid,
    output logic              resp_we,
    output logic [4:0]        resp_dest,
    output logic [31:0]       resp_data,
    output logic [1:0]        resp_fault,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state, state_next;
    lsu_op_t       op_in;
    logic [3:0]    op_q;
    logic [1:0]    k_q;
    logic [31:0]   ea, ea_q, rt_q, wdata, ldata;
    logic [4:0]    dest_q;
    logic [3:0]    be;
    logic [CW-1:0] cnt;
    logic          illegal, misalign, timeout_hit;

    assign ea          = req_base + {{16{req_offset[15]}}, req_offset};
    assign op_in       = lsu_op_t'(req_op);
    assign illegal     = req_op > 4'(OP_SW);
    assign misalign    = ((op_in == OP_LH || op_in == OP_LHU || op_in == OP_SH) && ea[0]) ||
                         ((op_in == OP_LW || op_in == OP_SW) && ea[1:0] != 2'b00);
    // a waitrequest drop on the final counted cycle completes instead of faulting
    assign timeout_hit = avm_waitrequest && cnt == CW'(TIMEOUT_CYCLES - 1);

    assign req_ready  = state == S_IDLE;
    assign resp_valid = state == S_RESP;
    assign resp_we    = resp_valid && resp_fault == F_NONE && is_load(op_q);
    assign resp_dest  = dest_q;

    // store steering uses the live request; load extraction uses the held op in ACCESS
    lsu_lane_align u_align (
        .op         (req_ready ? req_op : op_q),
        .k          (req_ready ? ea[1:0] : k_q),
        .rt         (req_ready ? req_store_data : rt_q),
        .readdata   (avm_readdata),
        .writedata  (wdata),
        .byteenable (be),
        .result     (ldata)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= S_IDLE;
        else       state <= state_next;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (req_valid) state_next = (illegal || misalign) ? S_RESP : S_ACCESS;
            S_ACCESS: if (!avm_waitrequest || timeout_hit) state_next = S_RESP;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q           <= '0;
            k_q            <= '0;
            ea_q           <= '0;
            rt_q           <= '0;
            dest_q         <= '0;
            cnt            <= '0;
            resp_data      <= '0;
            resp_fault     <= F_NONE;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
        end else if (state == S_IDLE && req_valid) begin
            op_q   <= req_op;
            k_q    <= ea[1:0];
            ea_q   <= ea;
            rt_q   <= req_rt_old;
            dest_q <= req_dest;
            cnt    <= '0;
            if (illegal || misalign) begin
                resp_fault <= illegal ? F_ILLEGAL : F_MISALIGN;
                resp_data  <= ea;
            end else begin
                resp_fault     <= F_NONE;
                avm_address    <= {ea[ADDR_W-1:2], 2'b00};
                avm_read       <= is_load(req_op);
                avm_write      <= is_store(req_op);
                avm_writedata  <= wdata;
                avm_byteenable <= be;
            end
        end else if (state == S_ACCESS) begin
            if (!avm_waitrequest) begin
                avm_read  <= 1'b0;
                avm_write <= 1'b0;
                resp_data <= ldata;
            end else if (timeout_hit) begin
                avm_read   <= 1'b0;
                avm_write  <= 1'b0;
                resp_fault <= F_TIMEOUT;
                resp_data  <= ea_q;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mips_lsu_avalon.sv
// tb_mips_lsu_avalon: directed and random ops against a byte-level reference model of the LSU.
module tb_mips_lsu_avalon;
    import mips_lsu_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0, reset = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic [3:0]  req_op = '0;
    logic [31:0] req_base = '0, req_store_data = '0, req_rt_old = '0;
    logic [15:0] req_offset = '0;
    logic [4:0]  req_dest = '0;
    logic        resp_valid, resp_we;
    logic [4:0]  resp_dest;
    logic [31:0] resp_data;
    logic [1:0]  resp_fault;
    logic [31:0] avm_address;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;

    int checks = 0, passed = 0, fails = 0;

    mips_lsu_avalon #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_base(req_base), .req_offset(req_offset),
        .req_store_data(req_store_data), .req_rt_old(req_rt_old), .req_dest(req_dest),
        .resp_valid(resp_valid), .resp_we(resp_we), .resp_dest(resp_dest),
        .resp_data(resp_data), .resp_fault(resp_fault), .avm_address(avm_address),
        .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: what a correct LSU must do, computed byte by byte from the op's definition
    task automatic model(input logic [3:0] op, input logic [31:0] base, input logic [15:0] off,
                         input logic [31:0] sd, input logic [31:0] rto, input logic [31:0] rdata,
                         input int waits, output logic [1:0] fault, output logic [31:0] data,
                         output logic we, output int strobes, output int lat, output logic rd,
                         output logic [3:0] be, output logic [31:0] wd, output logic [31:0] addr);
        logic [31:0] ea;
        logic [7:0]  m[4], r[4], o[4];
        logic [15:0] h;
        int k;
        ea = base + 32'($signed(off));
        k = int'(ea[1:0]);
        for (int i = 0; i < 4; i++) begin
            m[i] = rdata[8*i +: 8];
            r[i] = rto[8*i +: 8];
        end
        fault = 2'd0; data = 32'd0; we = 1'b0; strobes = 0; lat = 1; rd = 1'b0;
        be = 4'hF; wd = sd; addr = {ea[31:2], 2'b00};
        if (op > 4'd9) begin
            fault = 2'd3; data = ea;
        end else if (((op == 4'd2 || op == 4'd3 || op == 4'd8) && k % 2 == 1) ||
                     ((op == 4'd4 || op == 4'd9) && k != 0)) begin
            fault = 2'd1; data = ea;
        end else begin
            rd = op <= 4'd6;
            strobes = waits >= TO ? TO : waits + 1;
            lat = strobes + 1;
            if (waits >= TO) begin
                fault = 2'd2; data = ea;
            end else if (rd) begin
                we = 1'b1;
                h = {m[(k/2)*2+1], m[(k/2)*2]};
                case (op)
                    4'd0: data = 32'($signed(m[k]));
                    4'd1: data = 32'(m[k]);
                    4'd2: data = 32'($signed(h));
                    4'd3: data = 32'(h);
                    4'd4: data = rdata;
                    default: begin
                        for (int i = 0; i < 4; i++)
                            if (op == 4'd5) o[i] = (i >= 3 - k) ? m[(i - (3 - k)) & 3] : r[i];
                            else            o[i] = (i <= 3 - k) ? m[(i + k) & 3] : r[i];
                        data = {o[3], o[2], o[1], o[0]};
                    end
                endcase
            end
            if (op == 4'd7) begin be = 4'(1 << k); wd = {4{sd[7:0]}}; end
            if (op == 4'd8) begin be = k >= 2 ? 4'hC : 4'h3; wd = {2{sd[15:0]}}; end
        end
    endtask

    // Issue one op, act as an Avalon slave with `waits` stall cycles, compare against the model
    task automatic txn(input string tag, input logic [3:0] op, input logic [31:0] base,
                       input logic [15:0] off, input logic [31:0] sd, input logic [31:0] rto,
                       input logic [4:0] dest, input int waits, input logic [31:0] rdata,
                       output logic [31:0] obs_data, output logic [3:0] obs_be);
        logic [1:0]  e_fault;
        logic [31:0] e_data, e_wd, e_addr, a_addr, a_wd;
        logic        e_we, e_rd, a_rd, a_wr, got, unstable;
        logic [3:0]  e_be, a_be;
        int e_str, e_lat, strobes, lat;
        model(op, base, off, sd, rto, rdata, waits, e_fault, e_data, e_we, e_str, e_lat, e_rd,
              e_be, e_wd, e_addr);
        @(negedge clk);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_base = base; req_offset = off;
        req_store_data = sd; req_rt_old = rto; req_dest = dest;
        @(negedge clk);
        req_valid = 1'b0; req_op = 4'($urandom); req_base = $urandom;
        strobes = 0; lat = 1; got = 1'b0; unstable = 1'b0;
        a_rd = 1'b0; a_wr = 1'b0; a_addr = '0; a_wd = '0; a_be = '0; obs_data = 'x; obs_be = 'x;
        for (int c = 0; c < 20 && !got; c++) begin
            if (resp_valid) begin
                got = 1'b1;
                check({tag, "_fault"}, 32'(resp_fault), 32'(e_fault));
                check({tag, "_we"}, 32'(resp_we), 32'(e_we));
                check({tag, "_dest"}, 32'(resp_dest), 32'(dest));
                if (e_rd || e_fault != 2'd0) check({tag, "_data"}, resp_data, e_data);
                obs_data = resp_data;
            end else begin
                if (avm_read || avm_write) begin
                    strobes++;
                    if (strobes == 1) begin
                        a_rd = avm_read; a_wr = avm_write; a_addr = avm_address;
                        a_wd = avm_writedata; a_be = avm_byteenable;
                    end else if ({avm_read, avm_write, avm_address, avm_writedata, avm_byteenable}
                                 !== {a_rd, a_wr, a_addr, a_wd, a_be}) unstable = 1'b1;
                    avm_waitrequest = strobes <= waits;
                    avm_readdata = rdata;
                end else begin
                    avm_waitrequest = 1'b0;
                    avm_readdata = $urandom;
                end
                @(negedge clk);
                lat++;
            end
        end
        avm_waitrequest = 1'b0;
        check({tag, "_latency"}, got ? lat : -1, e_lat);
        check({tag, "_strobes"}, strobes, e_str);
        if (e_str > 0) begin
            check({tag, "_stable"}, 32'(unstable), 32'd0);
            check({tag, "_rdwr"}, {a_rd, a_wr}, {e_rd, !e_rd});
            check({tag, "_addr"}, a_addr, e_addr);
            check({tag, "_be"}, a_be, e_be);
            if (!e_rd) check({tag, "_wdata"}, a_wd, e_wd);
            obs_be = a_be;
        end
        @(negedge clk);
        check({tag, "_pulse"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic [3:0]  b;
        logic        seen;
        logic [3:0]  rop;
        logic [31:0] rbase;
        logic [15:0] roff;

        // reset state
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_strobes", {avm_read, avm_write}, 32'd0);
        check("rst_be", 32'(avm_byteenable), 32'd0);
        check("rst_data", resp_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        txn("sw", 4'(OP_SW), 32'h1000, 16'hFFFC, 32'hDEADBEEF, 32'h0, 5'd3, 0, 32'h0, d, b);
        check("sw_be_lit", 32'(b), 32'hF);
        txn("lb", 4'(OP_LB), 32'h2000, 16'h0003, 32'h0, 32'h0, 5'd4, 3, 32'h80FF1234, d, b);
        check("lb_lit", d, 32'hFFFFFF80);
        txn("lbu", 4'(OP_LBU), 32'h2000, 16'h0003, 32'h0, 32'h0, 5'd5, 3, 32'h80FF1234, d, b);
        check("lbu_lit", d, 32'h00000080);
        txn("lwl", 4'(OP_LWL), 32'h3000, 16'h0001, 32'h0, 32'hAABBCCDD, 5'd6, 1, 32'h11223344, d, b);
        check("lwl_lit", d, 32'h3344CCDD);
        txn("lwr", 4'(OP_LWR), 32'h3000, 16'h0001, 32'h0, 32'hAABBCCDD, 5'd7, 0, 32'h11223344, d, b);
        check("lwr_lit", d, 32'hAA112233);
        txn("lh_mis", 4'(OP_LH), 32'h4000, 16'h0001, 32'h0, 32'h0, 5'd8, 0, 32'h0, d, b);
        check("lh_mis_lit", d, 32'h00004001);
        txn("lw_to", 4'(OP_LW), 32'h7000, 16'h0010, 32'h0, 32'h0, 5'd9, 50, 32'h12345678, d, b);
        txn("lw_edge", 4'(OP_LW), 32'h7000, 16'h0014, 32'h0, 32'h0, 5'd10, TO - 1, 32'hCAFEF00D, d, b);
        check("lw_edge_lit", d, 32'hCAFEF00D);
        txn("illegal", 4'hC, 32'h8000, 16'h0000, 32'h0, 32'h0, 5'd11, 0, 32'h0, d, b);
        txn("neg_off", 4'(OP_LHU), 32'h0000_0001, 16'hFFFF, 32'h0, 32'h0, 5'd12, 0, 32'hBEEF0000, d, b);

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 10));
            rbase = $urandom;
            roff = 16'($urandom);
            if ($urandom_range(0, 3) != 0) begin rbase[1:0] = 2'b00; roff[1:0] = 2'($urandom); end
            txn($sformatf("rnd%0d", i), rop, rbase, roff, $urandom, $urandom, 5'($urandom),
                $urandom_range(0, 5), $urandom, d, b);
        end

        // reset while the slave is stalling
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'(OP_LW); req_base = 32'h6000; req_offset = 16'h0;
        @(negedge clk);
        req_valid = 1'b0;
        avm_waitrequest = 1'b1;
        check("mid_read", 32'(avm_read), 32'd1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("rst_read_drop", 32'(avm_read), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            seen |= resp_valid;
            @(negedge clk);
        end
        check("rst_no_resp", 32'(seen), 32'd0);
        check("rst_ready_after", 32'(req_ready), 32'd1);
        txn("sb_after", 4'(OP_SB), 32'h5000, 16'h0002, 32'h000000A5, 32'h0, 5'd1, 0, 32'h0, d, b);
        check("sb_after_be_lit", 32'(b), 32'b0100);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
